regfile_rdport: RTL and testbench

- 32-entry MIPS general-purpose register file with one write port and two registered read ports.
- The read side produces the A/B operand latches for the multicycle datapath. Reads launch on a read-enable and present data one cycle later with a valid flag.
- Includes same-cycle write-to-read bypass and a hardwired $0.
- Sits between instruction decode (register addresses) and the ALU operand muxes. The write port is driven by the writeback stage.

---
 rtl/regfile_rdport.sv | 78 +++++++
 tb/tb_regfile_rdport.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/regfile_rdport.sv
// 32-entry MIPS register file: one write port, two registered read ports with
// same-edge write bypass, hardwired $0 and a one-cycle read-valid pulse.
module regfile_rdport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rvalid,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rsel1;
    logic [DATA_W-1:0] rsel2;
    logic [DATA_W-1:0] rd1_p1;
    logic [DATA_W-1:0] rd2_p1;
    logic              vld_p1;

    // $0 wins over bypass, bypass wins over stored contents
    function automatic logic [DATA_W-1:0] read_sel(
        input logic [ADDR_W-1:0] a,
        input logic              w_en,
        input logic [ADDR_W-1:0] w_addr,
        input logic [DATA_W-1:0] w_data,
        input logic [DATA_W-1:0] stored
    );
        if (a == '0)
            return '0;
        else if (w_en && (w_addr == a))
            return w_data;
        else
            return stored;
    endfunction

    always_comb begin
        rsel1 = read_sel(ra1, we, wa, wd, mem[ra1]);
        rsel2 = read_sel(ra2, we, wa, wd, mem[ra2]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (we && (wa != '0)) begin
            mem[wa] <= wd;
        end
    end

    // Stage p1: operand latches; re=0 holds a snapshot of the last read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_p1 <= '0;
            rd2_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= re;
            if (re) begin
                rd1_p1 <= rsel1;
                rd2_p1 <= rsel2;
            end
        end
    end

    assign rd1    = rd1_p1;
    assign rd2    = rd2_p1;
    assign rvalid = vld_p1;

endmodule

// File: tb/tb_regfile_rdport.sv
// Directed bench for regfile_rdport: a register-array model checked every
// cycle plus literal expectations for each scenario.
module tb_regfile_rdport;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst_n;
    logic              re;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              rvalid;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    logic [DATA_W-1:0] m_regs [32];
    logic [DATA_W-1:0] m_rd1;
    logic [DATA_W-1:0] m_rd2;
    logic              m_vld;

    regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .re(re), .ra1(ra1), .ra2(ra2),
        .rd1(rd1), .rd2(rd2), .rvalid(rvalid),
        .we(we), .wa(wa), .wd(wd)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DATA_W-1:0] model_value(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
        if (we && wa == a) return wd;
        return m_regs[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_rd1 = '0;
            m_rd2 = '0;
            m_vld = 0;
        end else begin
            if (re) begin
                m_rd1 = model_value(ra1);
                m_rd2 = model_value(ra2);
            end
            m_vld = re;
            if (we && wa != 0) m_regs[wa] = wd;
        end
    end

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_rd1", rd1, m_rd1);
            check("model_rd2", rd2, m_rd2);
            check("model_rvalid", {31'b0, rvalid}, {31'b0, m_vld});
        end
    end

    initial begin
        rst_n = 1; re = 0; ra1 = 0; ra2 = 0; we = 0; wa = 0; wd = 0;
        #1 rst_n = 0;
        cmp_en = 1;
        repeat (2) @(negedge clk);
        check("reset_rd1", rd1, 32'h0);
        check("reset_rvalid", {31'b0, rvalid}, 32'h0);

        rst_n = 1; re = 1; ra1 = 5; ra2 = 31;
        @(negedge clk);
        check("rst_read_rd1", rd1, 32'h0);
        check("rst_read_rd2", rd2, 32'h0);
        check("rst_read_rvalid", {31'b0, rvalid}, 32'h1);

        re = 0; we = 1; wa = 7; wd = 32'hDEADBEEF;
        @(negedge clk);
        we = 0; re = 1; ra1 = 7; ra2 = 0;
        @(negedge clk);
        check("wr_rd_rd1", rd1, 32'hDEADBEEF);
        check("wr_rd_rd2", rd2, 32'h0);

        re = 1; ra1 = 9; ra2 = 9; we = 1; wa = 9; wd = 32'h12345678;
        @(negedge clk);
        check("bypass_rd1", rd1, 32'h12345678);
        check("bypass_rd2", rd2, 32'h12345678);
        we = 0; re = 0;
        @(negedge clk);
        re = 1; ra1 = 9; ra2 = 0;
        @(negedge clk);
        check("bypass_follow", rd1, 32'h12345678);

        we = 1; wa = 0; wd = 32'hFFFFFFFF; re = 1; ra1 = 0; ra2 = 7;
        @(negedge clk);
        check("zero_bypass", rd1, 32'h0);
        check("zero_other_port", rd2, 32'hDEADBEEF);
        we = 0;
        @(negedge clk);
        check("zero_reread", rd1, 32'h0);

        re = 0; we = 1; wa = 3; wd = 32'hA5A5A5A5;
        @(negedge clk);
        we = 0; re = 1; ra1 = 3;
        @(negedge clk);
        check("hold_first", rd1, 32'hA5A5A5A5);
        re = 0; we = 1; wa = 3; wd = 32'h0F0F0F0F;
        @(negedge clk);
        check("hold_snapshot", rd1, 32'hA5A5A5A5);
        check("hold_rvalid_drop", {31'b0, rvalid}, 32'h0);
        we = 0;
        @(negedge clk);
        check("hold_still", rd1, 32'hA5A5A5A5);
        re = 1; ra1 = 3;
        @(negedge clk);
        check("hold_newread", rd1, 32'h0F0F0F0F);

        ra1 = 7; ra2 = 3;
        @(negedge clk);
        check("b2b_rvalid1", {31'b0, rvalid}, 32'h1);
        check("b2b_rd1_a", rd1, 32'hDEADBEEF);
        ra1 = 9;
        @(negedge clk);
        check("b2b_rvalid2", {31'b0, rvalid}, 32'h1);
        check("b2b_rd1_b", rd1, 32'h12345678);

        re = 0; we = 1; wa = 10; wd = 32'h00000042;
        @(negedge clk);
        we = 0; re = 1; ra1 = 10;
        @(negedge clk);
        check("pre_arst_rd1", rd1, 32'h00000042);
        check("pre_arst_rvalid", {31'b0, rvalid}, 32'h1);
        re = 0;
        #2 rst_n = 0;
        #1;
        check("arst_rd1", rd1, 32'h0);
        check("arst_rvalid", {31'b0, rvalid}, 32'h0);
        @(negedge clk);
        rst_n = 1; re = 1; ra1 = 7; ra2 = 10;
        @(negedge clk);
        check("post_arst_rd1", rd1, 32'h0);
        check("post_arst_rd2", rd2, 32'h0);
        check("post_arst_rvalid", {31'b0, rvalid}, 32'h1);
        re = 0;
        @(negedge clk);
        cmp_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
